// File: rtl/poly_pkg.sv
// -----------------------------------------------------------------------------
// poly_pkg
// Shared constants, types and index helpers for the 4-BFU, 1024-coefficient
// poly-multiplier datapath.
//   - mode encodings carried on the 3-bit conf bus
//   - ring size constants
//   - per-BFU index record and write-back delay-line payload
//   - index arithmetic helpers used by the address generator
// -----------------------------------------------------------------------------
package poly_pkg;

    localparam logic [2:0] CONF_NTT  = 3'd1;
    localparam logic [2:0] CONF_PWM  = 3'd2;
    localparam logic [2:0] CONF_INTT = 3'd3;

    localparam int N_COEF  = 1024;
    localparam int LOG_N   = 10;
    localparam int BFU_NUM = 4;
    localparam int IDX_W   = 10;

    // Highest legal stage number (LOG_N - 1).
    localparam logic [3:0] STAGE_MAX = 4'd9;

    // One butterfly's read/twiddle indices.
    typedef struct packed {
        logic [IDX_W-1:0] top;
        logic [IDX_W-1:0] bot;
        logic [IDX_W-1:0] tw;
    } bfu_idx_t;

    // Payload carried from the read side to the write-back side.
    typedef struct packed {
        logic                       valid;
        logic [BFU_NUM*IDX_W-1:0]   top;
        logic [BFU_NUM*IDX_W-1:0]   bot;
        logic                       bank;
    } wb_entry_t;

    // Butterfly b of an NTT/INTT cycle at stage p, group k, offset block i.
    // Arithmetic is 11 bits wide and the result is truncated to IDX_W.
    // For J >= 4 the four butterflies share one group; for J < 4 the four
    // butterflies straddle several groups, so k is re-expanded into m = 4k+b.
    function automatic bfu_idx_t ntt_bfu_idx(input logic [3:0] p,
                                             input logic [8:0] k,
                                             input logic [8:0] i,
                                             input logic [1:0] b);
        logic [10:0] j_s;
        logic [10:0] m_s;
        logic [10:0] off_s;
        logic [10:0] top_s;
        logic [10:0] bot_s;
        logic [10:0] tw_s;
        bfu_idx_t    res_s;
        j_s = 11'd1 << p;
        m_s = {k, 2'b00} + {9'd0, b};
        if (p >= 4'd2) begin
            off_s = {i, 2'b00} + {9'd0, b};
            top_s = ({2'b00, k} << (p + 4'd1)) + off_s;
        end else begin
            off_s = m_s & (j_s - 11'd1);
            top_s = ((m_s >> p) << (p + 4'd1)) + off_s;
        end
        bot_s     = top_s + j_s;
        tw_s      = j_s + off_s;
        res_s.top = IDX_W'(top_s);
        res_s.bot = IDX_W'(bot_s);
        res_s.tw  = IDX_W'(tw_s);
        return res_s;
    endfunction

    // Butterfly b of a point-wise multiply cycle: adjacent coefficient pairs.
    function automatic bfu_idx_t pwm_bfu_idx(input logic [6:0] cnt,
                                             input logic [1:0] b);
        bfu_idx_t res_s;
        res_s.top = {cnt, 3'b000} + {7'd0, b, 1'b0};
        res_s.bot = {cnt, 3'b000} + {7'd0, b, 1'b1};
        res_s.tw  = {IDX_W{1'b0}};
        return res_s;
    endfunction

endpackage

// File: rtl/addr_delay_line.sv
// -----------------------------------------------------------------------------
// addr_delay_line
// Fixed-depth shift register that shifts every cycle; used to carry read-side
// indices to the write-back side after the butterfly pipeline latency.
// Ports:
//   clk  - clock
//   clr  - synchronous active-high clear of every stage
//   din  - WIDTH-bit entry captured each cycle
//   dout - entry captured DEPTH cycles earlier (registered)
// -----------------------------------------------------------------------------
module addr_delay_line #(
    parameter int WIDTH = 82,
    parameter int DEPTH = 11
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain; clear wipes all in-flight entries so no stale data escapes.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_r[s] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int s = 1; s < DEPTH; s++) begin
                stage_r[s] <= stage_r[s-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// -----------------------------------------------------------------------------
// ntt_addr_gen
// Per-cycle coefficient/twiddle address generator for four butterflies.
// Takes the control FSM loop indices and produces registered read and twiddle
// indices, plus write-back indices delayed by the butterfly latency.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   conf                - 1 NTT, 2 PWM, 3 INTT, others idle
//   valid_in            - loop indices valid
//   p, k, i             - stage, group, offset block
//   cnt_addr_gen        - linear counter for PWM
//   a_flag_neg          - ping-pong bank select
//   rd_valid, rd_top_idx, rd_bot_idx, tw_idx, rd_bank - read side (1 cycle)
//   wr_valid, wr_top_idx, wr_bot_idx, wr_bank         - read side delayed LAT
//   err                 - sticky illegal-stage flag
// BFU b occupies bits [IDX_W*b +: IDX_W] of every packed index bus.
// -----------------------------------------------------------------------------
module ntt_addr_gen #(
    parameter int BFU_NUM = 4,
    parameter int IDX_W   = 10,
    parameter int LAT     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               conf,
    input  logic                     valid_in,
    input  logic [3:0]               p,
    input  logic [8:0]               k,
    input  logic [8:0]               i,
    input  logic [6:0]               cnt_addr_gen,
    input  logic                     a_flag_neg,
    output logic                     rd_valid,
    output logic [BFU_NUM*IDX_W-1:0] rd_top_idx,
    output logic [BFU_NUM*IDX_W-1:0] rd_bot_idx,
    output logic [BFU_NUM*IDX_W-1:0] tw_idx,
    output logic                     rd_bank,
    output logic                     wr_valid,
    output logic [BFU_NUM*IDX_W-1:0] wr_top_idx,
    output logic [BFU_NUM*IDX_W-1:0] wr_bot_idx,
    output logic                     wr_bank,
    output logic                     err
);

    import poly_pkg::*;

    localparam int BUS_W = BFU_NUM * IDX_W;
    localparam int WB_W  = $bits(wb_entry_t);

    logic             rd_valid_r;
    logic [BUS_W-1:0] rd_top_r;
    logic [BUS_W-1:0] rd_bot_r;
    logic [BUS_W-1:0] tw_r;
    logic             rd_bank_r;
    logic             err_r;

    logic             rd_valid_nxt_s;
    logic [BUS_W-1:0] rd_top_nxt_s;
    logic [BUS_W-1:0] rd_bot_nxt_s;
    logic [BUS_W-1:0] tw_nxt_s;
    logic             err_nxt_s;
    bfu_idx_t         bfu_s;

    wb_entry_t        wb_in_s;
    wb_entry_t        wb_out_s;

    // Next read indices: hold last values unless a legal, valid cycle arrives.
    always_comb begin
        rd_valid_nxt_s = 1'b0;
        rd_top_nxt_s   = rd_top_r;
        rd_bot_nxt_s   = rd_bot_r;
        tw_nxt_s       = tw_r;
        err_nxt_s      = err_r;
        bfu_s          = '0;
        case (conf)
            CONF_NTT, CONF_INTT: begin
                if (valid_in == 1'b0) begin
                    rd_valid_nxt_s = 1'b0;
                end else if (p > STAGE_MAX) begin
                    // Illegal stage: flag it, drop the cycle, keep old indices.
                    err_nxt_s = 1'b1;
                end else begin
                    rd_valid_nxt_s = 1'b1;
                    for (int b = 0; b < BFU_NUM; b++) begin
                        bfu_s = ntt_bfu_idx(p, k, i, 2'(b));
                        rd_top_nxt_s[b*IDX_W +: IDX_W] = bfu_s.top;
                        rd_bot_nxt_s[b*IDX_W +: IDX_W] = bfu_s.bot;
                        tw_nxt_s[b*IDX_W +: IDX_W]     = bfu_s.tw;
                    end
                end
            end
            CONF_PWM: begin
                if (valid_in == 1'b1) begin
                    rd_valid_nxt_s = 1'b1;
                    for (int b = 0; b < BFU_NUM; b++) begin
                        bfu_s = pwm_bfu_idx(cnt_addr_gen, 2'(b));
                        rd_top_nxt_s[b*IDX_W +: IDX_W] = bfu_s.top;
                        rd_bot_nxt_s[b*IDX_W +: IDX_W] = bfu_s.bot;
                        tw_nxt_s[b*IDX_W +: IDX_W]     = bfu_s.tw;
                    end
                end else begin
                    rd_valid_nxt_s = 1'b0;
                end
            end
            default: begin
                rd_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Read-side output registers; reset clears everything including err.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_top_r   <= {BUS_W{1'b0}};
            rd_bot_r   <= {BUS_W{1'b0}};
            tw_r       <= {BUS_W{1'b0}};
            rd_bank_r  <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            rd_valid_r <= rd_valid_nxt_s;
            rd_top_r   <= rd_top_nxt_s;
            rd_bot_r   <= rd_bot_nxt_s;
            tw_r       <= tw_nxt_s;
            rd_bank_r  <= a_flag_neg;
            err_r      <= err_nxt_s;
        end
    end

    // Pack the registered read side into one write-back entry.
    always_comb begin
        wb_in_s.valid = rd_valid_r;
        wb_in_s.top   = rd_top_r;
        wb_in_s.bot   = rd_bot_r;
        wb_in_s.bank  = rd_bank_r;
    end

    addr_delay_line #(
        .WIDTH (WB_W),
        .DEPTH (LAT)
    ) u_wb_delay (
        .clk  (clk),
        .clr  (rst),
        .din  (wb_in_s),
        .dout (wb_out_s)
    );

    assign rd_valid   = rd_valid_r;
    assign rd_top_idx = rd_top_r;
    assign rd_bot_idx = rd_bot_r;
    assign tw_idx     = tw_r;
    assign rd_bank    = rd_bank_r;
    assign err        = err_r;

    assign wr_valid   = wb_out_s.valid;
    assign wr_top_idx = wb_out_s.top;
    assign wr_bot_idx = wb_out_s.bot;
    assign wr_bank    = wb_out_s.bank;

endmodule

// File: doc/ntt_addr_gen.md
# ntt_addr_gen

Address generator for the 4-BFU, 1024-coefficient poly-multiplier datapath. It sits directly downstream of the control FSM: each cycle it takes the FSM loop indices (stage `p`, group `k`, offset `i`, linear counter) and produces per-BFU coefficient read indices and twiddle indices. It also produces the matching write-back indices, delayed by the butterfly pipeline latency, plus the ping-pong bank selects.

## Interface
Parameters:
- `BFU_NUM`, 4: butterflies per cycle; fixed, only 4 supported.
- `IDX_W`, 10: coefficient and twiddle index width.
- `LAT`, 11: butterfly latency plus 1, in cycles, from read index to write index.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `conf`  in  3  mode: 1 = NTT, 2 = PWM, 3 = INTT; other values are idle.
- `valid_in`  in  1  loop indices valid this cycle.
- `p`  in  4  stage; legal range 0..9.
- `k`  in  9  group index.
- `i`  in  9  offset-block index.
- `cnt_addr_gen`  in  7  linear counter, 0..127.
- `a_flag_neg`  in  1  ping-pong select: 0 = read bank A / write B, 1 = read B / write A.
- `rd_valid`  out  1  read indices valid.
- `rd_top_idx`, `rd_bot_idx`  out  40  per-BFU indices; BFU b is in bits [10b+9:10b].
- `tw_idx`  out  40  per-BFU twiddle ROM index, same packing.
- `rd_bank`  out  1  registered `a_flag_neg`.
- `wr_valid`  out  1  write indices valid.
- `wr_top_idx`, `wr_bot_idx`  out  40  read indices delayed by `LAT`.
- `wr_bank`  out  1  `rd_bank` delayed by `LAT`.
- `err`  out  1  sticky illegal-stage flag.

## Operation
- Let J = 1<<p. In NTT/INTT, each cycle covers 4 butterflies of stage p.
- **J ≥ 4 (p = 2..9):**
  - offset = 4i + b
  - top = 2J·k + offset
  - bot = top + J
- **J < 4 (p = 0, 1):**
  - m = 4k + b
  - offset = m & (J−1)
  - top = ((m>>p)<<(p+1)) + offset
  - bot = top + J
  - `i` is ignored.
- **Twiddle:** tw = J + offset in both NTT and INTT. The twiddle ROM selects the inverse table externally.
- **PWM (conf 2):**
  - top = 8·cnt_addr_gen + 2b
  - bot = top + 1
  - tw = 0
  - `p`, `k`, `i` are ignored.
- **Width rules:** all arithmetic is done at 11 bits and truncated to `IDX_W`. Legal inputs never overflow; the largest value is 1023.
- **Idle:** when `valid_in`=0 or conf ∉ {1,2,3}, `rd_valid`=0 and index outputs hold their last values.
- **Illegal stage:** p > 9 with `valid_in`=1 in NTT/INTT sets `err`=1. That cycle's `rd_valid`=0, and `err` stays set until `rst`.
- **Write-back path:** a single `LAT`-deep shift register carries {rd_valid, rd_top_idx, rd_bot_idx, rd_bank} to the wr_* outputs. It shifts every cycle, so bubbles propagate as `wr_valid`=0.

## Timing
- Read latency is 1 cycle: inputs at edge n appear on rd_*/tw_idx after edge n+1, all registered.
- Write outputs appear exactly `LAT` cycles after the corresponding rd_* (default 12 cycles after the inputs).
- A stage change between consecutive cycles needs no bubble; every cycle is independent.
- **Reset:** all outputs go to 0 (including all index buses, `rd_bank`, `wr_bank`, `err`), and every delay-line entry is cleared.
- **Reset mid-operation:** in-flight writes are discarded; `wr_valid` stays 0 until `LAT` cycles after the first post-reset `rd_valid`.
- **`valid_in` and `rst` in the same cycle:** reset wins.

## Structure
- Shared package `poly_pkg`:
  - mode constants `CONF_NTT`, `CONF_PWM`, `CONF_INTT`
  - `N_COEF` = 1024, `LOG_N` = 10, `BFU_NUM`, `IDX_W`
- Sub-module `addr_delay_line`:
  - parameterised width and depth
  - synchronous active-high clear
  - instantiated once for the write-back path

## Test plan
- **NTT, J ≥ 4:** conf=1, p=3, k=5, i=1, valid_in=1 -> next cycle:
  - rd_top = {87,86,85,84}, rd_bot = {95,94,93,92}, tw = {15,14,13,12}
  - after `LAT` cycles, wr_top = {87,86,85,84} with wr_valid=1.
- **Small stages:**
  - p=0, k=10 -> top = {86,84,82,80}, bot = {87,85,83,81}, tw = all 1.
  - p=1, k=10 -> top = {84,81,80,85}... no: top = {85,84,81,80}, bot = {87,86,83,82}, tw = {3,2,3,2}.
- **Last stage, INTT, and banks:** p=9, k=0, i=127 -> top = {511..508}, bot = {1023..1020}, tw = {1023..1020}. Repeat with conf=3: identical indices, and rd_bank follows a_flag_neg=1.
- **PWM:** conf=2, cnt_addr_gen=127 -> top = {1022,1020,1018,1016}, bot = {1023,1021,1019,1017}, tw = 0.
- **Error, bubbles and reset:** all in one directed sequence.
  - p=12 with valid_in=1 -> err=1, rd_valid=0, and err persists.
  - A 3-cycle valid_in gap -> exactly 3 wr_valid=0 cycles, `LAT` later.
  - rst asserted mid-stream -> all outputs 0 next cycle, and no stale wr_valid afterwards.
